alu_muldiv: RTL

Parametrised multiply/divide unit for the execute stage, the multi-cycle companion to the single-cycle ALU. It accepts signed/unsigned multiply and divide operations plus direct HI/LO writes, holds the HI/LO register pair, and exposes a busy flag so the hazard unit can stall HI/LO readers and further MDU operations. Data width and per-operation latency are parameters.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/mdu_compute.sv | 69 ++++++
 rtl/alu_muldiv.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_pkg                                                |
// | Description : Shared operation encodings, default MDU latencies and  |
// |               small decode helpers for the execute-stage units.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package alu_pkg;

  // Multiply/divide unit operation codes; 6 and 7 decode as NOP.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  // Default latencies from accept edge to HI/LO update.
  localparam int c_MUL_CYCLES = 5;
  localparam int c_DIV_CYCLES = 10;

  // Sequencer states for the multi-cycle unit.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_compute.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mdu_compute                                            |
// | Description : Combinational signed/unsigned product and quotient/    |
// |               remainder, with divide-by-zero suppression.            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mdu_compute
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_wr
);

  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  logic                 w_signed;
  logic                 w_mul;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_prod;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_b_div;
  logic [WIDTH-1:0]     w_q_mag;
  logic [WIDTH-1:0]     w_r_mag;
  logic [WIDTH-1:0]     w_q;
  logic [WIDTH-1:0]     w_r;

  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_mul    = is_mul(i_op);

  // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product
  // are then correct for both signed and unsigned operands.
  assign w_a_ext = {{WIDTH{w_signed & i_a[WIDTH-1]}}, i_a};
  assign w_b_ext = {{WIDTH{w_signed & i_b[WIDTH-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed division on magnitudes: quotient truncates toward zero and the
  // remainder follows the dividend. The most-negative / -1 case falls out
  // naturally: quotient magnitude 2^(WIDTH-1) negates back to a, rem 0.
  assign w_a_neg  = w_signed & i_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;
  assign w_b_zero = (i_b == '0);
  // Substitute 1 for a zero divisor so the divider never sees /0; the
  // result is discarded through o_wr anyway.
  assign w_b_div  = w_b_zero ? c_ONE : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_div;
  assign w_r_mag  = w_a_mag % w_b_div;
  assign w_q      = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_r      = w_a_neg ? -w_r_mag : w_r_mag;

  assign o_hi = w_mul ? w_prod[2*WIDTH-1:WIDTH] : w_r;
  assign o_lo = w_mul ? w_prod[WIDTH-1:0]       : w_q;
  assign o_wr = w_mul | ~w_b_zero;

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_muldiv                                             |
// | Description : Multi-cycle multiply/divide unit with HI/LO register   |
// |               pair, busy flag and one-cycle done pulse.              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = c_MUL_CYCLES,
  parameter int DIV_CYCLES = c_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int c_CW   = $clog2(c_MAXL + 1);
  localparam logic [c_CW-1:0] c_MUL_LOAD = c_CW'(MUL_CYCLES);
  localparam logic [c_CW-1:0] c_DIV_LOAD = c_CW'(DIV_CYCLES);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [c_CW-1:0]  r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             w_accept;
  logic             w_commit;
  logic             w_mthi;
  logic             w_mtlo;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_res_wr;

  // Arithmetic works on the operands captured at the accepting edge.
  mdu_compute #(
    .WIDTH (WIDTH)
  ) u_compute (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo),
    .o_wr (w_res_wr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode: accept multi-cycle ops in IDLE, commit on last count.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (is_mul(op) || is_div(op)) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end
          w_mthi = (op == OP_MTHI);
          w_mtlo = (op == OP_MTLO);
        end
      end
      S_RUN: begin
        if (r_cnt == c_CNT_ONE) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latency counter: load on accept, count down while running.
  always_ff @(posedge clk) begin
    if (reset)                r_cnt <= '0;
    else if (w_accept)        r_cnt <= is_mul(op) ? c_MUL_LOAD : c_DIV_LOAD;
    else if (r_state == S_RUN) r_cnt <= r_cnt - c_CNT_ONE;
  end

  // Operand capture so later changes on a/b/op cannot disturb the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= op;
      r_a  <= a;
      r_b  <= b;
    end
  end

  // HI/LO: commit of a finished operation, or direct MTHI/MTLO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (w_res_wr) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end else begin
      if (w_mthi) r_hi <= a;
      if (w_mtlo) r_lo <= a;
    end
  end

  // Done pulses in the first cycle after commit, even for divide-by-zero.
  always_ff @(posedge clk) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_commit;
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire
